// File: rtl/wormhole_output_arbiter.sv
// Output-port scheduler: round-robin arbitration over 5 inputs with wormhole
// locking from HEAD to TAIL, gated by a downstream credit counter.
`timescale 1ns/1ps
module wormhole_output_arbiter #(
  parameter int CREDITS = 15,
  parameter int CNT_W   = 4,
  parameter int FLIT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          valid_in,
  input  logic [5*FLIT_W-1:0] flit_in,
  input  logic                credit_inc,
  output logic [4:0]          pop,
  output logic [4:0]          grant,
  output logic                valid_out,
  output logic [FLIT_W-1:0]   data_out,
  output logic                output_available,
  output logic [CNT_W-1:0]    credits,
  output logic                err_proto
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic [0:0]        state;
  logic [2:0]        owner;
  logic [2:0]        rr_ptr;
  logic [1:0]        ftype [5];
  logic [FLIT_W-1:0] sel_flit;
  logic [2:0]        winner;
  logic [3:0]        idx;
  logic              found;
  logic              has_credit;
  logic              proto_bad;
  logic              xfer;

  function automatic logic [2:0] next_port(input logic [2:0] p);
    return (p == 3'd4) ? 3'd0 : p + 3'd1;
  endfunction

  assign has_credit = (credits != '0);
  assign xfer       = |pop;

  always_comb begin
    for (int unsigned i = 0; i < 5; i++)
      ftype[i] = flit_in[FLIT_W*i + FLIT_W-1 -: 2];
  end

  // Round-robin search starting at rr_ptr; bit 1 of the type marks HEAD/SINGLE.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!found && valid_in[idx[2:0]] && ftype[idx[2:0]][1]) begin
        found  = 1'b1;
        winner = idx[2:0];
      end
    end
  end

  always_comb begin
    pop       = '0;
    proto_bad = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        for (int unsigned i = 0; i < 5; i++)
          if (valid_in[i] && !ftype[i][1]) proto_bad = 1'b1;
        if (has_credit && found) pop[winner] = 1'b1;
      end else begin
        if (valid_in[owner] && ftype[owner][1]) proto_bad = 1'b1;
        if (valid_in[owner] && has_credit) pop[owner] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_flit = '0;
    for (int unsigned i = 0; i < 5; i++)
      if (pop[i]) sel_flit = flit_in[FLIT_W*i +: FLIT_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= '0;
      rr_ptr           <= '0;
      grant            <= '0;
      valid_out        <= 1'b0;
      data_out         <= '0;
      output_available <= 1'b1;
      credits          <= CNT_W'(CREDITS);
      err_proto        <= 1'b0;
    end else begin
      valid_out <= xfer;
      if (xfer) data_out <= sel_flit;
      if (proto_bad) err_proto <= 1'b1;

      if (xfer && !credit_inc) begin
        credits <= credits - 1'b1;
      end else if (credit_inc && !xfer) begin
        if (credits == CNT_W'(CREDITS)) err_proto <= 1'b1;
        else                            credits   <= credits + 1'b1;
      end

      if (state == IDLE) begin
        if (xfer) begin
          if (ftype[winner] == T_SINGLE) begin
            rr_ptr <= next_port(winner);
          end else begin
            state            <= ACTIVE;
            owner            <= winner;
            grant            <= 5'b00001 << winner;
            output_available <= 1'b0;
          end
        end
      end else if (xfer && ftype[owner] == T_TAIL) begin
        state            <= IDLE;
        grant            <= '0;
        output_available <= 1'b1;
        rr_ptr           <= next_port(owner);
      end
    end
  end

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Self-checking bench for wormhole_output_arbiter: directed scenarios plus a
// randomized run against a packet-level reference model.
`timescale 1ns/1ps
module tb_wormhole_output_arbiter;

  localparam int CREDITS = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  valid_in = '0;
  logic [79:0] flit_in = '0;
  logic        credit_inc = 1'b0;
  logic [4:0]  pop;
  logic [4:0]  grant;
  logic        valid_out;
  logic [15:0] data_out;
  logic        output_available;
  logic [3:0]  credits;
  logic        err_proto;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] q [5][$];
  logic [4:0]  hold = '0;

  wormhole_output_arbiter #(.CREDITS(15), .CNT_W(4), .FLIT_W(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .flit_in(flit_in),
    .credit_inc(credit_inc), .pop(pop), .grant(grant), .valid_out(valid_out),
    .data_out(data_out), .output_available(output_available),
    .credits(credits), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  task automatic drive_inputs();
    for (int i = 0; i < 5; i++) begin
      valid_in[i] = (q[i].size() > 0) && !hold[i];
      flit_in[16*i +: 16] = (q[i].size() > 0) ? q[i][0] : 16'h0000;
    end
  endtask

  // One clock: present queue heads, sample pop mid-cycle, retire popped flits.
  task automatic cycle(output logic [4:0] p);
    drive_inputs();
    @(negedge clk);
    p = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      if (p[i] && q[i].size() > 0) void'(q[i].pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    credit_inc = 1'b0;
    hold = '0;
    for (int i = 0; i < 5; i++) q[i].delete();
    drive_inputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] p;
    reset = 1'b1;
    drive_inputs();
    #1;
    n_checks++; if (pop !== 5'b0) $display("FAIL reset_pop_during: got %b expected 00000", pop); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) cycle(p);
    n_checks++; if (grant !== 5'b0) $display("FAIL reset_grant: got %b expected 00000", grant); else n_pass++;
    n_checks++; if (p !== 5'b0) $display("FAIL reset_pop: got %b expected 00000", p); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid_out: got %b expected 0", valid_out); else n_pass++;
    n_checks++; if (output_available !== 1'b1) $display("FAIL reset_avail: got %b expected 1", output_available); else n_pass++;
    n_checks++; if (credits !== 4'd15) $display("FAIL reset_credits: got %0d expected 15", credits); else n_pass++;
    n_checks++; if (err_proto !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_proto); else n_pass++;
  endtask

  task automatic test_single();
    logic [4:0] p;
    do_reset();
    q[2].push_back(16'hC0AB);
    cycle(p);
    n_checks++; if (p !== 5'b00100) $display("FAIL single_pop: got %b expected 00100", p); else n_pass++;
    n_checks++; if (valid_out !== 1'b1) $display("FAIL single_valid: got %b expected 1", valid_out); else n_pass++;
    n_checks++; if (data_out !== 16'hC0AB) $display("FAIL single_data: got %h expected c0ab", data_out); else n_pass++;
    n_checks++; if (credits !== 4'd14) $display("FAIL single_credits: got %0d expected 14", credits); else n_pass++;
    n_checks++; if (output_available !== 1'b1) $display("FAIL single_avail: got %b expected 1", output_available); else n_pass++;
    n_checks++; if (grant !== 5'b0) $display("FAIL single_grant: got %b expected 00000", grant); else n_pass++;
    // rr_ptr is now 3: with inputs 0,2,4 competing, 4 wins, then 0.
    q[0].push_back(16'hC001); q[2].push_back(16'hC002); q[4].push_back(16'hC004);
    cycle(p);
    n_checks++; if (p !== 5'b10000) $display("FAIL rr_after_single: got %b expected 10000", p); else n_pass++;
    cycle(p);
    n_checks++; if (p !== 5'b00001) $display("FAIL rr_wrap: got %b expected 00001", p); else n_pass++;
    n_checks++; if (credits !== 4'd12) $display("FAIL rr_credits: got %0d expected 12", credits); else n_pass++;
  endtask

  task automatic test_wormhole();
    logic [4:0]  p;
    logic [15:0] exp_data [4] = '{16'h8001, 16'h0002, 16'h4003, 16'h8100};
    logic [4:0]  exp_grant [4] = '{5'b00001, 5'b00001, 5'b00000, 5'b01000};
    logic [4:0]  exp_pop [4] = '{5'b00001, 5'b00001, 5'b00001, 5'b01000};
    do_reset();
    q[0].push_back(16'h8001); q[0].push_back(16'h0002); q[0].push_back(16'h4003);
    q[3].push_back(16'h8100);
    for (int c = 0; c < 4; c++) begin
      cycle(p);
      n_checks++; if (p !== exp_pop[c]) $display("FAIL worm_pop[%0d]: got %b expected %b", c, p, exp_pop[c]); else n_pass++;
      n_checks++; if (grant !== exp_grant[c]) $display("FAIL worm_grant[%0d]: got %b expected %b", c, grant, exp_grant[c]); else n_pass++;
      n_checks++; if (data_out !== exp_data[c]) $display("FAIL worm_data[%0d]: got %h expected %h", c, data_out, exp_data[c]); else n_pass++;
    end
    n_checks++; if (output_available !== 1'b0) $display("FAIL worm_avail: got %b expected 0", output_available); else n_pass++;
  endtask

  task automatic test_credit_stall();
    logic [4:0] p;
    int pops = 0;
    do_reset();
    q[1].push_back(16'h8000);
    for (int i = 1; i <= 18; i++) q[1].push_back(16'h0000 | 16'(i));
    q[1].push_back(16'h4013);
    for (int c = 0; c < 18; c++) begin
      cycle(p);
      if (p != 5'b0) pops++;
    end
    n_checks++; if (pops !== 15) $display("FAIL stall_pops: got %0d expected 15", pops); else n_pass++;
    n_checks++; if (p !== 5'b0) $display("FAIL stall_pop_zero: got %b expected 00000", p); else n_pass++;
    n_checks++; if (credits !== 4'd0) $display("FAIL stall_credits: got %0d expected 0", credits); else n_pass++;
    n_checks++; if (grant !== 5'b00010) $display("FAIL stall_grant: got %b expected 00010", grant); else n_pass++;
    credit_inc = 1'b1;
    cycle(p);
    credit_inc = 1'b0;
    n_checks++; if (p !== 5'b0) $display("FAIL stall_no_bypass: got %b expected 00000", p); else n_pass++;
    n_checks++; if (credits !== 4'd1) $display("FAIL stall_credit_back: got %0d expected 1", credits); else n_pass++;
    cycle(p);
    n_checks++; if (p !== 5'b00010) $display("FAIL stall_one_pop: got %b expected 00010", p); else n_pass++;
    n_checks++; if (credits !== 4'd0) $display("FAIL stall_credits_again: got %0d expected 0", credits); else n_pass++;
    n_checks++; if (data_out !== 16'h000F) $display("FAIL stall_data: got %h expected 000f", data_out); else n_pass++;
  endtask

  task automatic test_credit_edges();
    logic [4:0] p;
    do_reset();
    for (int i = 0; i < 8; i++) q[0].push_back(16'hC000 | 16'(i));
    for (int c = 0; c < 8; c++) cycle(p);
    n_checks++; if (credits !== 4'd7) $display("FAIL edge_credits7: got %0d expected 7", credits); else n_pass++;
    q[0].push_back(16'hC0FF);
    credit_inc = 1'b1;
    cycle(p);
    credit_inc = 1'b0;
    n_checks++; if (p !== 5'b00001) $display("FAIL edge_coincident_pop: got %b expected 00001", p); else n_pass++;
    n_checks++; if (credits !== 4'd7) $display("FAIL edge_coincident: got %0d expected 7", credits); else n_pass++;
    do_reset();
    credit_inc = 1'b1;
    cycle(p);
    credit_inc = 1'b0;
    n_checks++; if (credits !== 4'd15) $display("FAIL edge_saturate: got %0d expected 15", credits); else n_pass++;
    n_checks++; if (err_proto !== 1'b1) $display("FAIL edge_overflow_err: got %b expected 1", err_proto); else n_pass++;
  endtask

  task automatic test_proto_err();
    logic [4:0] p;
    do_reset();
    q[4].push_back(16'h0055);
    cycle(p);
    n_checks++; if (p !== 5'b0) $display("FAIL proto_pop: got %b expected 00000", p); else n_pass++;
    n_checks++; if (err_proto !== 1'b1) $display("FAIL proto_err: got %b expected 1", err_proto); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL proto_valid: got %b expected 0", valid_out); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [4:0] p;
    do_reset();
    credit_inc = 1'b1;
    cycle(p);
    credit_inc = 1'b0;
    q[0].push_back(16'h8011); q[0].push_back(16'h0012);
    q[0].push_back(16'h0013); q[0].push_back(16'h4014);
    cycle(p);
    cycle(p);
    n_checks++; if (grant !== 5'b00001) $display("FAIL midrst_locked: got %b expected 00001", grant); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (pop !== 5'b0) $display("FAIL midrst_pop: got %b expected 00000", pop); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (grant !== 5'b0) $display("FAIL midrst_grant: got %b expected 00000", grant); else n_pass++;
    n_checks++; if (output_available !== 1'b1) $display("FAIL midrst_avail: got %b expected 1", output_available); else n_pass++;
    n_checks++; if (credits !== 4'd15) $display("FAIL midrst_credits: got %0d expected 15", credits); else n_pass++;
    n_checks++; if (err_proto !== 1'b0) $display("FAIL midrst_err: got %b expected 0", err_proto); else n_pass++;
  endtask

  task automatic refill();
    for (int i = 0; i < 5; i++) begin
      if (q[i].size() < 4) begin
        int len = $urandom_range(1, 4);
        if (len == 1) begin
          q[i].push_back(16'hC000 | 16'($urandom_range(0, 16'h3FFF)));
        end else begin
          q[i].push_back(16'h8000 | 16'($urandom_range(0, 16'h3FFF)));
          for (int b = 0; b < len - 2; b++) begin
            if ($urandom_range(0, 19) == 0) q[i].push_back(16'h8000 | 16'($urandom_range(0, 16'h3FFF)));
            else                            q[i].push_back(16'($urandom_range(0, 16'h3FFF)));
          end
          q[i].push_back(16'h4000 | 16'($urandom_range(0, 16'h3FFF)));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [4:0]  p;
    logic [4:0]  exp_pop;
    logic [1:0]  ty;
    bit          m_locked = 0;
    bit          m_err = 0;
    bit          m_vo = 0;
    int          m_owner = 0;
    int          m_rr = 0;
    int          m_cred = CREDITS;
    int          win;
    logic [15:0] m_data = '0;
    logic [15:0] hd;
    bit          vin [5];
    do_reset();
    for (int c = 0; c < 400; c++) begin
      refill();
      hold = 5'($urandom) & 5'($urandom);
      credit_inc = ($urandom_range(0, 99) < 45);
      for (int i = 0; i < 5; i++) vin[i] = !hold[i];
      win = -1;
      if (!m_locked) begin
        for (int i = 0; i < 5; i++)
          if (vin[i] && q[i][0][15] == 1'b0) m_err = 1;
        if (m_cred > 0)
          for (int k = 0; k < 5; k++) begin
            int j = (m_rr + k) % 5;
            if (win < 0 && vin[j] && q[j][0][15] == 1'b1) win = j;
          end
      end else begin
        if (vin[m_owner] && q[m_owner][0][15] == 1'b1) m_err = 1;
        if (vin[m_owner] && m_cred > 0) win = m_owner;
      end
      exp_pop = (win >= 0) ? (5'b00001 << win) : 5'b00000;
      hd = (win >= 0) ? q[win][0] : 16'h0000;
      cycle(p);
      n_checks++; if (p !== exp_pop) $display("FAIL rand_pop[%0d]: got %b expected %b", c, p, exp_pop); else n_pass++;
      m_vo = (win >= 0);
      if (win >= 0) begin
        ty = hd[15:14];
        m_data = hd;
        if (!m_locked) begin
          if (ty == 2'b11) m_rr = (win + 1) % 5;
          else begin m_locked = 1; m_owner = win; end
        end else if (ty == 2'b01) begin
          m_locked = 0;
          m_rr = (m_owner + 1) % 5;
        end
      end
      m_cred = m_cred - (win >= 0 ? 1 : 0) + (credit_inc ? 1 : 0);
      if (m_cred > CREDITS) begin m_cred = CREDITS; m_err = 1; end
      n_checks++; if (grant !== (m_locked ? 5'(1 << m_owner) : 5'b0)) $display("FAIL rand_grant[%0d]: got %b locked %0d owner %0d", c, grant, m_locked, m_owner); else n_pass++;
      n_checks++; if (valid_out !== m_vo) $display("FAIL rand_valid[%0d]: got %b expected %b", c, valid_out, m_vo); else n_pass++;
      n_checks++; if (data_out !== m_data) $display("FAIL rand_data[%0d]: got %h expected %h", c, data_out, m_data); else n_pass++;
      n_checks++; if (output_available !== !m_locked) $display("FAIL rand_avail[%0d]: got %b expected %b", c, output_available, !m_locked); else n_pass++;
      n_checks++; if (credits !== 4'(m_cred)) $display("FAIL rand_credits[%0d]: got %0d expected %0d", c, credits, m_cred); else n_pass++;
      n_checks++; if (err_proto !== m_err) $display("FAIL rand_err[%0d]: got %b expected %b", c, err_proto, m_err); else n_pass++;
    end
    credit_inc = 1'b0;
    hold = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wormhole();
    test_credit_stall();
    test_credit_edges();
    test_proto_err();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wormhole_output_arbiter.md
Name: wormhole_output_arbiter

Overview:
- Per-output-port scheduler for the 5-port router: one instance per output (north, west, east, south, ni).
- Shares its output link among the 5 input buffers using round-robin arbitration with wormhole locking. Once a head flit is granted, the output stays with that input until its tail flit is sent.
- Gates every transfer on a downstream credit counter, so a downstream FIFO never overflows.

Parameters:
- CREDITS, 15, initial and maximum downstream credit count (usable slots of the 16-entry downstream FIFO).
- CNT_W, 4, width of the credit counter; must hold CREDITS.
- FLIT_W, 16, flit width. Bits [FLIT_W-1:FLIT_W-2] carry the flit type.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  5  bit i = input buffer i has a flit at its head.
- flit_in  input  80  packed flits; input i occupies [16i+15:16i].
- credit_inc  input  1  1-cycle pulse from downstream = one slot freed.
- pop  output  5  combinational one-hot; bit i = flit of input i consumed this cycle.
- grant  output  5  registered one-hot owner while locked; 0 when idle.
- valid_out  output  1  registered; data_out holds a valid flit.
- data_out  output  16  registered outgoing flit.
- output_available  output  1  registered; 1 when in IDLE (not locked).
- credits  output  CNT_W  current credit count.
- err_proto  output  1  sticky protocol-error flag.

Behaviour:
- Flit type, bits [15:14]:
  - 10 = HEAD
  - 00 = BODY
  - 01 = TAIL
  - 11 = SINGLE (head and tail in one flit)
- Reset values (asynchronous): state=IDLE, rr_ptr=0, grant=0, valid_out=0, data_out=0, output_available=1, credits=CREDITS, err_proto=0. pop is 0 while reset is asserted.
- A transfer occurs in a cycle when exactly one pop bit is 1. pop[i] requires credits!=0; there is no same-cycle bypass of credit_inc.
- Latency: the flit popped in cycle N appears on data_out with valid_out=1 in cycle N+1. With no transfer, valid_out=0 and data_out holds its last value.

State machine, IDLE:
- Candidates are inputs i with valid_in[i]=1 and type HEAD or SINGLE.
- Winner = first candidate searching rr_ptr, rr_ptr+1, ... mod 5.
- If credits!=0 and a winner exists:
  - pop[winner]=1 (head flit sent in the same cycle).
  - If SINGLE: stay in IDLE; rr_ptr <= winner+1 mod 5.
  - If HEAD: go to ACTIVE; owner <= winner; grant <= onehot(winner); output_available <= 0.
- If credits==0: no arbitration, rr_ptr unchanged.
- If valid_in[i]=1 with type BODY or TAIL while in IDLE: err_proto <= 1. The flit is never popped.

State machine, ACTIVE:
- pop[owner] = valid_in[owner] & (credits!=0). All other pop bits are 0; other inputs wait.
- When the owner's TAIL is popped: go to IDLE; grant <= 0; output_available <= 1; rr_ptr <= owner+1 mod 5. New arbitration begins the following cycle.
- If the owner presents HEAD or SINGLE: err_proto <= 1. The flit is still forwarded, treated as BODY, and the lock is held.

Credits:
- next = credits − xfer + credit_inc.
- xfer and credit_inc in the same cycle → unchanged.
- credit_inc while credits==CREDITS with no xfer → saturates at CREDITS and sets err_proto.
- A transfer never happens at credits=0, so there is no underflow.

Reset mid-packet: the lock is dropped immediately and all state returns to its reset values. A partial packet upstream is the system's responsibility.

Test Plan:
- Reset, then idle for 5 cycles → grant=0, pop=0, valid_out=0, output_available=1, credits=15, err_proto=0.
- valid_in=00100, flit 2=C0AB (SINGLE) → pop=00100 in cycle N; in N+1 valid_out=1, data_out=C0AB, credits=14, output_available=1, rr_ptr=3.
- rr_ptr=0; input 0 sends HEAD 8001, BODY 0002, TAIL 4003; input 3 holds HEAD 8100 throughout:
  - grant=00001 for 3 transfer cycles; pop[3]=0 throughout.
  - Cycle after TAIL pop: pop=01000, grant=01000.
  - data_out sequence: 8001, 0002, 4003, 8100.
- No credit_inc; input 1 streams a 20-flit packet → exactly 15 pops, then pop=0 with credits=0 and grant still 00010. One credit_inc pulse → exactly one pop in the next cycle, credits back to 0.
- credit_inc coincident with a transfer at credits=7 → credits stays 7. credit_inc at credits=15 → credits=15, err_proto=1.
- BODY flit 0055 on input 4 while IDLE → pop=0, err_proto=1. Assert reset in the middle of a packet → next cycle grant=0, output_available=1, credits=15, err_proto=0.
